// File: rtl/rvfi_bus_env.sv
// rtl/rvfi_bus_env.sv - environment model for one split request/response bus port
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   req_valid/req_wr/req_addr, req_ready
//                           request channel from the core under test
//   rsp_valid/rsp_data/rsp_addr
//                           in-order response strobe, data and answered address
//   ch_req_ready, ch_rsp_valid, ch_rsp_data
//                           free nondeterministic choices from the wrapper
//   in_flight               accepted requests still awaiting a response
//   fairness_ok             stall and response-latency counters below their bounds
//   protocol_err            sticky flag for core-side handshake violations

module rvfi_bus_env #(
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int MAX_OUTSTANDING = 2,
   parameter int MAX_REQ_STALL   = 4,
   parameter int MAX_RSP_LAT     = 4,
   parameter int WRITES_HAVE_RSP = 0,
   parameter int FORCE_FAIR      = 0
) (
   input  logic                                   clock,
   input  logic                                   reset,
   input  logic                                   req_valid,
   output logic                                   req_ready,
   input  logic                                   req_wr,
   input  logic [ADDR_W-1:0]                      req_addr,
   output logic                                   rsp_valid,
   output logic [DATA_W-1:0]                      rsp_data,
   output logic [ADDR_W-1:0]                      rsp_addr,
   input  logic                                   ch_req_ready,
   input  logic                                   ch_rsp_valid,
   input  logic [DATA_W-1:0]                      ch_rsp_data,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   in_flight,
   output logic                                   fairness_ok,
   output logic                                   protocol_err
);

   localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1);
   localparam int PTR_W   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int STALL_W = $clog2(MAX_REQ_STALL + 1);
   localparam int AGE_W   = $clog2(MAX_RSP_LAT + 1);

   localparam logic [CNT_W-1:0]   FULL_CNT    = CNT_W'(MAX_OUTSTANDING);
   localparam logic [PTR_W-1:0]   PTR_LAST    = PTR_W'(MAX_OUTSTANDING - 1);
   localparam logic [STALL_W-1:0] STALL_MAX   = STALL_W'(MAX_REQ_STALL);
   localparam logic [STALL_W-1:0] STALL_FORCE = STALL_W'(MAX_REQ_STALL - 1);
   localparam logic [AGE_W-1:0]   AGE_MAX     = AGE_W'(MAX_RSP_LAT);
   localparam logic [AGE_W-1:0]   AGE_FORCE   = AGE_W'(MAX_RSP_LAT - 1);

   // Storage is rounded up to a power of two so the pointer always indexes it
   // exactly; only the first MAX_OUTSTANDING entries are ever used.
   logic [ADDR_W-1:0]  tag_mem [2**PTR_W];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [STALL_W-1:0] req_stall_cnt;
   logic [AGE_W-1:0]   rsp_age;

   // Snapshot of the request as it stood at the previous edge, used to check
   // that a stalled request is held stable.
   logic               stalled_q;
   logic               wr_q;
   logic [ADDR_W-1:0]  addr_q;

   logic full;
   logic tracked;
   logic push;
   logic pop;
   logic stall_now;
   logic proto_viol;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      full       = (in_flight == FULL_CNT);
      tracked    = !req_wr || (WRITES_HAVE_RSP != 0);
      // Readiness is never offered while full, even if a pop happens this cycle.
      req_ready  = !reset && req_valid && !full &&
                   (ch_req_ready || ((FORCE_FAIR != 0) && (req_stall_cnt == STALL_FORCE)));
      rsp_valid  = !reset && (in_flight != '0) &&
                   (ch_rsp_valid || ((FORCE_FAIR != 0) && (rsp_age == AGE_FORCE)));
      push       = req_valid && req_ready && tracked;
      pop        = rsp_valid;
      stall_now  = req_valid && !req_ready;
      proto_viol = stalled_q && (!req_valid || (req_addr != addr_q) || (req_wr != wr_q));
      rsp_data   = ch_rsp_data;
      rsp_addr   = tag_mem[rd_ptr];
      fairness_ok = (req_stall_cnt < STALL_MAX) && (rsp_age < AGE_MAX);
   end

   always_ff @(posedge clock) begin
      if (push) begin
         tag_mem[wr_ptr] <= req_addr;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         in_flight     <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         req_stall_cnt <= '0;
         rsp_age       <= '0;
         protocol_err  <= 1'b0;
         stalled_q     <= 1'b0;
         wr_q          <= 1'b0;
         addr_q        <= '0;
      end else begin
         if (push) begin
            wr_ptr <= ptr_next(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_next(rd_ptr);
         end

         case ({push, pop})
            2'b10:   in_flight <= in_flight + CNT_W'(1);
            2'b01:   in_flight <= in_flight - CNT_W'(1);
            default: in_flight <= in_flight;
         endcase

         if (stall_now) begin
            if (req_stall_cnt != STALL_MAX) begin
               req_stall_cnt <= req_stall_cnt + STALL_W'(1);
            end
         end else begin
            req_stall_cnt <= '0;
         end

         // A pop clears the age so the next head starts waiting from zero.
         if ((in_flight != '0) && !rsp_valid) begin
            if (rsp_age != AGE_MAX) begin
               rsp_age <= rsp_age + AGE_W'(1);
            end
         end else begin
            rsp_age <= '0;
         end

         if (proto_viol) begin
            protocol_err <= 1'b1;
         end

         stalled_q <= stall_now;
         wr_q      <= req_wr;
         addr_q    <= req_addr;
      end
   end

endmodule

// File: tb/tb_rvfi_bus_env.sv
// tb/tb_rvfi_bus_env.sv - self-checking bench for rvfi_bus_env

module tb_rvfi_bus_env;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_wr = 1'b0;
   logic [31:0] req_addr = '0;
   logic        ch_req_ready = 1'b0;
   logic        ch_rsp_valid = 1'b0;
   logic [31:0] ch_rsp_data = '0;

   // default instance (d_), writes answered (w_), forced fairness (f_), depth one (o_)
   logic d_req_ready, d_rsp_valid, d_fair, d_perr;
   logic [31:0] d_rsp_data, d_rsp_addr;
   logic [1:0]  d_in_flight;
   logic w_req_ready, w_rsp_valid, w_fair, w_perr;
   logic [31:0] w_rsp_data, w_rsp_addr;
   logic [1:0]  w_in_flight;
   logic f_req_ready, f_rsp_valid, f_fair, f_perr;
   logic [31:0] f_rsp_data, f_rsp_addr;
   logic [1:0]  f_in_flight;
   logic o_req_ready, o_rsp_valid, o_fair, o_perr;
   logic [31:0] o_rsp_data, o_rsp_addr;
   logic [0:0]  o_in_flight;

   int tests = 0;
   int fails = 0;
   int sel = 0;

   logic        s_req_ready, s_rsp_valid, s_fair, s_perr;
   logic [31:0] s_rsp_data, s_rsp_addr;
   int          s_in_flight;

   always #5 clock = ~clock;

   rvfi_bus_env u_def (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(d_req_ready),
      .req_wr(req_wr), .req_addr(req_addr), .rsp_valid(d_rsp_valid), .rsp_data(d_rsp_data),
      .rsp_addr(d_rsp_addr), .ch_req_ready(ch_req_ready), .ch_rsp_valid(ch_rsp_valid),
      .ch_rsp_data(ch_rsp_data), .in_flight(d_in_flight), .fairness_ok(d_fair),
      .protocol_err(d_perr));

   rvfi_bus_env #(.WRITES_HAVE_RSP(1)) u_wr (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(w_req_ready),
      .req_wr(req_wr), .req_addr(req_addr), .rsp_valid(w_rsp_valid), .rsp_data(w_rsp_data),
      .rsp_addr(w_rsp_addr), .ch_req_ready(ch_req_ready), .ch_rsp_valid(ch_rsp_valid),
      .ch_rsp_data(ch_rsp_data), .in_flight(w_in_flight), .fairness_ok(w_fair),
      .protocol_err(w_perr));

   rvfi_bus_env #(.FORCE_FAIR(1)) u_ff (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(f_req_ready),
      .req_wr(req_wr), .req_addr(req_addr), .rsp_valid(f_rsp_valid), .rsp_data(f_rsp_data),
      .rsp_addr(f_rsp_addr), .ch_req_ready(ch_req_ready), .ch_rsp_valid(ch_rsp_valid),
      .ch_rsp_data(ch_rsp_data), .in_flight(f_in_flight), .fairness_ok(f_fair),
      .protocol_err(f_perr));

   rvfi_bus_env #(.MAX_OUTSTANDING(1)) u_one (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(o_req_ready),
      .req_wr(req_wr), .req_addr(req_addr), .rsp_valid(o_rsp_valid), .rsp_data(o_rsp_data),
      .rsp_addr(o_rsp_addr), .ch_req_ready(ch_req_ready), .ch_rsp_valid(ch_rsp_valid),
      .ch_rsp_data(ch_rsp_data), .in_flight(o_in_flight), .fairness_ok(o_fair),
      .protocol_err(o_perr));

   always_comb begin
      s_req_ready = d_req_ready; s_rsp_valid = d_rsp_valid; s_fair = d_fair; s_perr = d_perr;
      s_rsp_data = d_rsp_data; s_rsp_addr = d_rsp_addr; s_in_flight = int'(d_in_flight);
      case (sel)
         1: begin
            s_req_ready = w_req_ready; s_rsp_valid = w_rsp_valid; s_fair = w_fair; s_perr = w_perr;
            s_rsp_data = w_rsp_data; s_rsp_addr = w_rsp_addr; s_in_flight = int'(w_in_flight);
         end
         2: begin
            s_req_ready = f_req_ready; s_rsp_valid = f_rsp_valid; s_fair = f_fair; s_perr = f_perr;
            s_rsp_data = f_rsp_data; s_rsp_addr = f_rsp_addr; s_in_flight = int'(f_in_flight);
         end
         3: begin
            s_req_ready = o_req_ready; s_rsp_valid = o_rsp_valid; s_fair = o_fair; s_perr = o_perr;
            s_rsp_data = o_rsp_data; s_rsp_addr = o_rsp_addr; s_in_flight = int'(o_in_flight);
         end
         default: ;
      endcase
   end

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0;
      ch_req_ready = 1'b0; ch_rsp_valid = 1'b0;
      next_cycle();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h100;
      ch_req_ready = 1'b1; ch_rsp_valid = 1'b1;
      @(negedge clock);
      tests++; if (d_req_ready !== 1'b0) begin fails++; $display("FAIL reset_rdy got=%0b exp=0", d_req_ready); end
      tests++; if (d_rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rspv got=%0b exp=0", d_rsp_valid); end
      next_cycle();
      @(negedge clock);
      tests++; if (d_in_flight !== 2'd0) begin fails++; $display("FAIL reset_inflight got=%0d exp=0", d_in_flight); end
      tests++; if (d_perr !== 1'b0) begin fails++; $display("FAIL reset_perr got=%0b exp=0", d_perr); end
      tests++; if (d_fair !== 1'b1) begin fails++; $display("FAIL reset_fair got=%0b exp=1", d_fair); end
      next_cycle();
      reset = 1'b0; req_valid = 1'b0;
   endtask

   task automatic test_fill_drain();
      do_reset();
      ch_req_ready = 1'b1; ch_rsp_valid = 1'b0; req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h100;
      @(negedge clock);
      tests++; if (d_req_ready !== 1'b1) begin fails++; $display("FAIL fill_rdy0 got=%0b exp=1", d_req_ready); end
      next_cycle();
      req_addr = 32'h104;
      @(negedge clock);
      tests++; if (d_req_ready !== 1'b1) begin fails++; $display("FAIL fill_rdy1 got=%0b exp=1", d_req_ready); end
      tests++; if (d_in_flight !== 2'd1) begin fails++; $display("FAIL fill_if1 got=%0d exp=1", d_in_flight); end
      next_cycle();
      req_addr = 32'h108;
      @(negedge clock);
      tests++; if (d_req_ready !== 1'b0) begin fails++; $display("FAIL fill_full_rdy got=%0b exp=0", d_req_ready); end
      tests++; if (d_in_flight !== 2'd2) begin fails++; $display("FAIL fill_if2 got=%0d exp=2", d_in_flight); end
      next_cycle();
      ch_rsp_valid = 1'b1;
      @(negedge clock);
      tests++; if (d_rsp_valid !== 1'b1) begin fails++; $display("FAIL drain_v0 got=%0b exp=1", d_rsp_valid); end
      tests++; if (d_rsp_addr !== 32'h100) begin fails++; $display("FAIL drain_a0 got=%0h exp=100", d_rsp_addr); end
      tests++; if (d_req_ready !== 1'b0) begin fails++; $display("FAIL drain_full_pop_rdy got=%0b exp=0", d_req_ready); end
      next_cycle();
      @(negedge clock);
      tests++; if (d_in_flight !== 2'd1) begin fails++; $display("FAIL drain_if1 got=%0d exp=1", d_in_flight); end
      tests++; if (d_rsp_addr !== 32'h104) begin fails++; $display("FAIL drain_a1 got=%0h exp=104", d_rsp_addr); end
      tests++; if (d_req_ready !== 1'b1) begin fails++; $display("FAIL drain_rdy got=%0b exp=1", d_req_ready); end
      next_cycle();
      req_valid = 1'b0;
      @(negedge clock);
      tests++; if (d_in_flight !== 2'd1) begin fails++; $display("FAIL pushpop_if got=%0d exp=1", d_in_flight); end
      tests++; if (d_rsp_addr !== 32'h108) begin fails++; $display("FAIL drain_a2 got=%0h exp=108", d_rsp_addr); end
      next_cycle();
      @(negedge clock);
      tests++; if (d_in_flight !== 2'd0) begin fails++; $display("FAIL drain_if0 got=%0d exp=0", d_in_flight); end
      tests++; if (d_rsp_valid !== 1'b0) begin fails++; $display("FAIL drain_empty_v got=%0b exp=0", d_rsp_valid); end
      tests++; if (d_perr !== 1'b0) begin fails++; $display("FAIL drain_perr got=%0b exp=0", d_perr); end
      next_cycle();
      ch_rsp_valid = 1'b0;
   endtask

   task automatic test_writes();
      do_reset();
      ch_req_ready = 1'b1; ch_rsp_valid = 1'b1; req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h200;
      @(negedge clock);
      tests++; if (d_req_ready !== 1'b1) begin fails++; $display("FAIL wr_rdy_def got=%0b exp=1", d_req_ready); end
      tests++; if (w_req_ready !== 1'b1) begin fails++; $display("FAIL wr_rdy_rsp got=%0b exp=1", w_req_ready); end
      next_cycle();
      req_valid = 1'b0; req_wr = 1'b0;
      @(negedge clock);
      tests++; if (w_rsp_valid !== 1'b1) begin fails++; $display("FAIL wr_rsp_v got=%0b exp=1", w_rsp_valid); end
      tests++; if (w_rsp_addr !== 32'h200) begin fails++; $display("FAIL wr_rsp_a got=%0h exp=200", w_rsp_addr); end
      tests++; if (d_in_flight !== 2'd0) begin fails++; $display("FAIL wr_def_if got=%0d exp=0", d_in_flight); end
      next_cycle();
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         tests++; if (d_rsp_valid !== 1'b0) begin fails++; $display("FAIL wr_def_nrsp%0d got=%0b exp=0", i, d_rsp_valid); end
         tests++; if (w_rsp_valid !== 1'b0) begin fails++; $display("FAIL wr_one_rsp%0d got=%0b exp=0", i, w_rsp_valid); end
         next_cycle();
      end
      ch_rsp_valid = 1'b0;
   endtask

   task automatic test_force_fair();
      do_reset();
      ch_req_ready = 1'b0; ch_rsp_valid = 1'b0; req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h300;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clock);
         tests++; if (f_req_ready !== (i == 4)) begin fails++; $display("FAIL ff_rdy_c%0d got=%0b exp=%0b", i, f_req_ready, i == 4); end
         tests++; if (f_fair !== 1'b1) begin fails++; $display("FAIL ff_fair_c%0d got=%0b exp=1", i, f_fair); end
         next_cycle();
      end
      req_valid = 1'b0;
      @(negedge clock);
      tests++; if (f_in_flight !== 2'd1) begin fails++; $display("FAIL ff_if got=%0d exp=1", f_in_flight); end
      next_cycle();
   endtask

   task automatic test_rsp_age();
      do_reset();
      ch_req_ready = 1'b1; ch_rsp_valid = 1'b0; req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h500;
      @(negedge clock);
      tests++; if (d_req_ready !== 1'b1) begin fails++; $display("FAIL age_acc got=%0b exp=1", d_req_ready); end
      next_cycle();
      req_valid = 1'b0; ch_req_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         tests++; if (d_fair !== (i < 4)) begin fails++; $display("FAIL age_fair_c%0d got=%0b exp=%0b", i, d_fair, i < 4); end
         next_cycle();
      end
      ch_rsp_valid = 1'b1;
      @(negedge clock);
      tests++; if (d_rsp_valid !== 1'b1) begin fails++; $display("FAIL age_rsp got=%0b exp=1", d_rsp_valid); end
      tests++; if (d_fair !== 1'b0) begin fails++; $display("FAIL age_fair_rsp got=%0b exp=0", d_fair); end
      next_cycle();
      ch_rsp_valid = 1'b0;
      @(negedge clock);
      tests++; if (d_fair !== 1'b1) begin fails++; $display("FAIL age_fair_after got=%0b exp=1", d_fair); end
      next_cycle();
   endtask

   task automatic test_one_deep();
      do_reset();
      ch_req_ready = 1'b1; ch_rsp_valid = 1'b0; req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h400;
      @(negedge clock);
      tests++; if (o_req_ready !== 1'b1) begin fails++; $display("FAIL one_acc0 got=%0b exp=1", o_req_ready); end
      next_cycle();
      req_addr = 32'h404; ch_rsp_valid = 1'b1;
      @(negedge clock);
      tests++; if (o_in_flight !== 1'b1) begin fails++; $display("FAIL one_if_a got=%0d exp=1", o_in_flight); end
      tests++; if (o_rsp_addr !== 32'h400) begin fails++; $display("FAIL one_rsp_a got=%0h exp=400", o_rsp_addr); end
      tests++; if (o_req_ready !== 1'b0) begin fails++; $display("FAIL one_full_rdy got=%0b exp=0", o_req_ready); end
      next_cycle();
      @(negedge clock);
      tests++; if (o_in_flight !== 1'b0) begin fails++; $display("FAIL one_if_b got=%0d exp=0", o_in_flight); end
      tests++; if (o_req_ready !== 1'b1) begin fails++; $display("FAIL one_acc1 got=%0b exp=1", o_req_ready); end
      next_cycle();
      req_valid = 1'b0; ch_rsp_valid = 1'b0;
      @(negedge clock);
      tests++; if (o_in_flight !== 1'b1) begin fails++; $display("FAIL one_if_c got=%0d exp=1", o_in_flight); end
      tests++; if (o_rsp_addr !== 32'h404) begin fails++; $display("FAIL one_head got=%0h exp=404", o_rsp_addr); end
      tests++; if (o_perr !== 1'b0) begin fails++; $display("FAIL one_perr got=%0b exp=0", o_perr); end
      next_cycle();
   endtask

   task automatic test_protocol();
      do_reset();
      ch_req_ready = 1'b1; ch_rsp_valid = 1'b0; req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h500;
      next_cycle();
      ch_req_ready = 1'b0; req_addr = 32'h300;
      @(negedge clock);
      tests++; if (d_req_ready !== 1'b0) begin fails++; $display("FAIL prot_stall got=%0b exp=0", d_req_ready); end
      next_cycle();
      req_addr = 32'h304;
      @(negedge clock);
      tests++; if (d_perr !== 1'b0) begin fails++; $display("FAIL prot_early got=%0b exp=0", d_perr); end
      next_cycle();
      req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         tests++; if (d_perr !== 1'b1) begin fails++; $display("FAIL prot_sticky%0d got=%0b exp=1", i, d_perr); end
         next_cycle();
      end
      reset = 1'b1; ch_rsp_valid = 1'b1;
      @(negedge clock);
      tests++; if (d_rsp_valid !== 1'b0) begin fails++; $display("FAIL prot_rst_rspv got=%0b exp=0", d_rsp_valid); end
      next_cycle();
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         tests++; if (d_perr !== 1'b0) begin fails++; $display("FAIL prot_clr%0d got=%0b exp=0", i, d_perr); end
         tests++; if (d_in_flight !== 2'd0) begin fails++; $display("FAIL prot_if%0d got=%0d exp=0", i, d_in_flight); end
         tests++; if (d_rsp_valid !== 1'b0) begin fails++; $display("FAIL prot_rspv%0d got=%0b exp=0", i, d_rsp_valid); end
         next_cycle();
      end
      ch_rsp_valid = 1'b0;
   endtask

   // Reference: a queue of addresses awaiting answers plus counts of how long
   // the current request has stalled and how long the head has waited.
   task automatic test_random(input int s, input int max_out, input bit whr, input bit ff, input int cycles);
      logic [31:0] q[$];
      int    stall, age;
      bit    perr, sp, pw, exp_rdy, exp_rv;
      logic [31:0] pa;
      sel = s;
      do_reset();
      stall = 0; age = 0; perr = 0; sp = 0; pw = 0; pa = '0;
      for (int c = 0; c < cycles; c++) begin
         if (!(sp && $urandom_range(0, 63) != 0)) begin
            req_valid = ($urandom_range(0, 9) < 7);
            req_wr    = ($urandom_range(0, 9) < 3);
            req_addr  = $urandom & 32'h0000_FFFC;
         end
         ch_req_ready = $urandom_range(0, 1);
         ch_rsp_valid = ($urandom_range(0, 9) < 4);
         ch_rsp_data  = $urandom;
         @(negedge clock);
         exp_rdy = req_valid && (q.size() < max_out) && (ch_req_ready || (ff && stall == 3));
         exp_rv  = (q.size() != 0) && (ch_rsp_valid || (ff && age == 3));
         tests++; if (s_req_ready !== exp_rdy) begin fails++; $display("FAIL rnd%0d_rdy c%0d got=%0b exp=%0b", s, c, s_req_ready, exp_rdy); end
         tests++; if (s_rsp_valid !== exp_rv) begin fails++; $display("FAIL rnd%0d_rspv c%0d got=%0b exp=%0b", s, c, s_rsp_valid, exp_rv); end
         tests++; if (s_in_flight != q.size()) begin fails++; $display("FAIL rnd%0d_if c%0d got=%0d exp=%0d", s, c, s_in_flight, q.size()); end
         tests++; if (s_fair !== (stall < 4 && age < 4)) begin fails++; $display("FAIL rnd%0d_fair c%0d got=%0b exp=%0b", s, c, s_fair, stall < 4 && age < 4); end
         tests++; if (s_perr !== perr) begin fails++; $display("FAIL rnd%0d_perr c%0d got=%0b exp=%0b", s, c, s_perr, perr); end
         if (exp_rv) begin
            tests++; if (s_rsp_addr !== q[0]) begin fails++; $display("FAIL rnd%0d_addr c%0d got=%0h exp=%0h", s, c, s_rsp_addr, q[0]); end
            tests++; if (s_rsp_data !== ch_rsp_data) begin fails++; $display("FAIL rnd%0d_data c%0d got=%0h exp=%0h", s, c, s_rsp_data, ch_rsp_data); end
         end
         if (sp && (!req_valid || req_addr != pa || req_wr != pw)) perr = 1;
         age   = (q.size() != 0 && !exp_rv) ? ((age < 4) ? age + 1 : 4) : 0;
         stall = (req_valid && !exp_rdy) ? ((stall < 4) ? stall + 1 : 4) : 0;
         if (exp_rv) void'(q.pop_front());
         if (exp_rdy && (!req_wr || whr)) q.push_back(req_addr);
         sp = req_valid && !exp_rdy; pa = req_addr; pw = req_wr;
         next_cycle();
      end
      sel = 0;
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_writes();
      test_force_fair();
      test_rsp_age();
      test_one_deep();
      test_protocol();
      test_random(0, 2, 1'b0, 1'b0, 400);
      test_random(1, 2, 1'b1, 1'b0, 400);
      test_random(2, 2, 1'b0, 1'b1, 400);
      test_random(3, 1, 1'b0, 1'b0, 400);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rvfi_bus_env.md
Name: rvfi_bus_env

Overview:
- Parametrised formal/simulation environment model for one split request/response bus port of a core under test (instruction or data side); one instance per port.
- Generalises the hand-written per-port environment logic in core wrappers:
  - in-flight tracking up to a configurable depth
  - in-order address tag FIFO
  - optional responses to writes
  - bounded-latency fairness with optional forcing
  - sticky protocol checking
- Free nondeterministic choices enter as input ports (driven by `rvformal_rand_reg` in a wrapper, or by random stimulus in simulation). The block itself is fully synthesisable.

Parameters:
- ADDR_W, 32, request address width
- DATA_W, 32, request/response data width
- MAX_OUTSTANDING, 2, max accepted-but-unanswered requests (1..8); also the tag FIFO depth
- MAX_REQ_STALL, 4, fairness bound on consecutive cycles req_valid && !req_ready
- MAX_RSP_LAT, 4, fairness bound on cycles the FIFO head waits for its response
- WRITES_HAVE_RSP, 0, 1: writes also generate a response; 0: only reads do
- FORCE_FAIR, 0, 1: force ready/valid at the bound; 0: only report via fairness_ok

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request from core
- req_ready  out  1  request accepted when req_valid && req_ready
- req_wr  in  1  1 = write
- req_addr  in  ADDR_W  request address
- rsp_valid  out  1  response strobe (one cycle per response)
- rsp_data  out  DATA_W  response data
- rsp_addr  out  ADDR_W  address of the request being answered (FIFO head)
- ch_req_ready  in  1  free choice: offer ready this cycle
- ch_rsp_valid  in  1  free choice: respond this cycle
- ch_rsp_data  in  DATA_W  free choice: response data
- in_flight  out  $clog2(MAX_OUTSTANDING+1)  current outstanding count
- fairness_ok  out  1  both stall/latency counters below bounds
- protocol_err  out  1  sticky core-side handshake violation

Behaviour:
- Reset (synchronous, active-high):
  - clears in_flight, FIFO pointers, req_stall_cnt, rsp_age and protocol_err to 0
  - req_ready and rsp_valid are gated to 0 while reset is high
  - reset mid-transaction discards all pending entries; no response is issued for them
- Tracked request: an accepted request needs a response iff !req_wr || WRITES_HAVE_RSP. Only tracked requests are pushed to the FIFO and counted in in_flight.
- full = (in_flight == MAX_OUTSTANDING).
- req_ready (combinational) = !reset && req_valid && !full && (ch_req_ready || (FORCE_FAIR && req_stall_cnt == MAX_REQ_STALL-1)).
  - When full, ready is never offered, even in the same cycle a response pops.
- rsp_valid (combinational) = !reset && in_flight != 0 && (ch_rsp_valid || (FORCE_FAIR && rsp_age == MAX_RSP_LAT-1)).
  - Minimum latency is 1 cycle: an entry pushed at edge N can respond in cycle N+1 at the earliest.
- rsp_data = ch_rsp_data; rsp_addr = FIFO head. Both are don't-care when rsp_valid = 0.
- FIFO is in-order: push on tracked accept, pop on rsp_valid.
  - Pointers wrap modulo MAX_OUTSTANDING.
  - Simultaneous push and pop: in_flight is unchanged, both pointers advance.
- req_stall_cnt:
  - increments, saturating at MAX_REQ_STALL, while req_valid && !req_ready
  - cleared otherwise
- rsp_age:
  - increments, saturating at MAX_RSP_LAT, while in_flight != 0 && !rsp_valid
  - cleared on rsp_valid or when empty
  - a pop restarts the age for the next head at 0
- fairness_ok = (req_stall_cnt < MAX_REQ_STALL) && (rsp_age < MAX_RSP_LAT). The wrapper uses it in restrict/assume.
- protocol_err is set, and held until reset, if any of these holds in the cycle after a stalled request (req_valid && !req_ready at the previous edge):
  - req_valid is now 0
  - req_addr changed
  - req_wr changed
- No ready is ever offered without req_valid, so the environment never accepts phantom requests.

Test Plan:
- Default params, ch_req_ready = 1, ch_rsp_valid = 0:
  - reads to 0x100 then 0x104 accepted in consecutive cycles
  - third read stalled (req_ready = 0), in_flight = 2
  - ch_rsp_valid = 1 → rsp_addr 0x100 then 0x104, in_flight returns to 0
- WRITES_HAVE_RSP = 0: write to 0x200 accepted → in_flight stays 0, no rsp_valid ever. With WRITES_HAVE_RSP = 1: the same write produces one response with rsp_addr = 0x200.
- FORCE_FAIR = 1, ch_req_ready = 0, req_valid held → req_ready = 1 exactly in the 4th cycle of the request; fairness_ok stays 1.
- FORCE_FAIR = 0, ch_rsp_valid = 0 with one read pending → rsp_age reaches 4 after 4 cycles, fairness_ok = 0 and stays 0 until ch_rsp_valid = 1.
- MAX_OUTSTANDING = 1, full:
  - response and new request in the same cycle → new request not accepted that cycle
  - accepted next cycle; in_flight sequence 1, 0, 1
- Stalled request at 0x300 changes to 0x304 → protocol_err = 1 next cycle and stays 1; reset clears it, along with in_flight = 0 and rsp_valid = 0 thereafter.
